mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D caches, the arbiter and the shared slow memory.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              mem_read_I;
    logic              mem_write_I;
    logic [ADDR_W-1:0] mem_addr_I;
    logic [DATA_W-1:0] mem_wdata_I;
    logic [DATA_W-1:0] mem_rdata_I;
    logic              mem_ready_I;

    logic              mem_read_D;
    logic              mem_write_D;
    logic [ADDR_W-1:0] mem_addr_D;
    logic [DATA_W-1:0] mem_wdata_D;
    logic [DATA_W-1:0] mem_rdata_D;
    logic              mem_ready_D;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  mem_read_I, mem_write_I, mem_addr_I, mem_wdata_I,
        output mem_rdata_I, mem_ready_I,
        input  mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D,
        output mem_rdata_D, mem_ready_D,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output mem_read_I, mem_write_I, mem_addr_I, mem_wdata_I,
        input  mem_rdata_I, mem_ready_I,
        output mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D,
        input  mem_rdata_D, mem_ready_D,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto one shared memory, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin on collisions; default is fixed D-side priority.
module mem_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus,
    output logic [1:0]   dbg_state,
    output logic         dbg_last_gnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t state;
    state_t next_state;
    logic   last_gnt;
    logic   req_i;
    logic   req_d;
    logic   pick_d;

    assign req_i = bus.mem_read_I | bus.mem_write_I;
    assign req_d = bus.mem_read_D | bus.mem_write_D;

`ifdef ARB_ROUND_ROBIN_EN
    assign pick_d = ~last_gnt;
`else
    assign pick_d = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state != IDLE)
                last_gnt <= (next_state == GNT_D);
        end
    end

    // A granted side holds the grant until mem_ready even if its request drops.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_i && req_d)
                    next_state = pick_d ? GNT_D : GNT_I;
                else if (req_d)
                    next_state = GNT_D;
                else if (req_i)
                    next_state = GNT_I;
            end
            GNT_I:   if (bus.mem_ready) next_state = IDLE;
            GNT_D:   if (bus.mem_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.mem_ready_I = 1'b0;
        bus.mem_ready_D = 1'b0;
        case (state)
            GNT_I: begin
                bus.mem_read    = bus.mem_read_I;
                bus.mem_write   = bus.mem_write_I;
                bus.mem_addr    = bus.mem_addr_I;
                bus.mem_wdata   = bus.mem_wdata_I;
                bus.mem_ready_I = bus.mem_ready;
            end
            GNT_D: begin
                bus.mem_read    = bus.mem_read_D;
                bus.mem_write   = bus.mem_write_D;
                bus.mem_addr    = bus.mem_addr_D;
                bus.mem_wdata   = bus.mem_wdata_D;
                bus.mem_ready_D = bus.mem_ready;
            end
            default: ;
        endcase
    end

    assign bus.mem_rdata_I = bus.mem_rdata;
    assign bus.mem_rdata_D = bus.mem_rdata;

    assign dbg_state    = state;
    assign dbg_last_gnt = last_gnt;

endmodule
